// File: rtl/vx_tl_mem_responder.sv
// ============================================================================
// Module   : vx_tl_mem_responder
// Brief    : TileLink-UL responder backed by a 16-byte-line internal memory,
//            with an in-order, credit-limited response queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_tl_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          MEM_LINES = 1024,
    parameter int          RSP_DEPTH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [2:0]     a_bits_opcode,
    input  logic [2:0]     a_bits_param,
    input  logic [3:0]     a_bits_size,
    input  logic [14:0]    a_bits_source,
    input  logic [31:0]    a_bits_address,
    input  logic [15:0]    a_bits_mask,
    input  logic [127:0]   a_bits_data,
    input  logic           a_bits_corrupt,
    output logic           d_valid,
    input  logic           d_ready,
    output logic [2:0]     d_bits_opcode,
    output logic [1:0]     d_bits_param,
    output logic [3:0]     d_bits_size,
    output logic [14:0]    d_bits_source,
    output logic [2:0]     d_bits_sink,
    output logic           d_bits_denied,
    output logic [127:0]   d_bits_data,
    output logic           d_bits_corrupt
);

    localparam int c_idx_w = $clog2(MEM_LINES);
    localparam int c_ptr_w = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(RSP_DEPTH + 1);
    localparam int c_rsp_w = 3 + 4 + 15 + 1 + 1 + 128;

    // ---------------------------------------------------------------- decode
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_a_ready;
    logic               w_a_fire;
    logic [31:0]        w_off;
    logic [27:0]        w_line;
    logic [c_idx_w-1:0] w_idx;
    logic               w_is_get;
    logic               w_is_put;
    logic               w_legal;
    logic               w_do_write;
    logic               w_get_ok;
    logic               w_unused;

    assign w_a_ready  = !reset && (r_cnt < c_cnt_w'(RSP_DEPTH));
    assign w_a_fire   = a_valid && w_a_ready;
    assign w_off      = a_bits_address - BASE_ADDR;
    assign w_line     = w_off[31:4];
    assign w_idx      = w_line[c_idx_w-1:0];
    assign w_is_get   = (a_bits_opcode == 3'd4);
    assign w_is_put   = (a_bits_opcode == 3'd0) || (a_bits_opcode == 3'd1);
    assign w_legal    = (a_bits_address >= BASE_ADDR) && (w_line < 28'(MEM_LINES)) &&
                        (a_bits_address[3:0] == 4'd0) && (a_bits_size == 4'd4) &&
                        (w_is_get || w_is_put);
    assign w_do_write = w_a_fire && w_is_put && w_legal && !a_bits_corrupt;
    assign w_get_ok   = w_is_get && w_legal;
    assign w_unused   = ^{a_bits_param, w_off[3:0]};

    // ---------------------------------------------------------------- memory
    // Line storage is deliberately not reset so written data survives reset.
    logic [127:0] r_mem [MEM_LINES];
    logic [127:0] r_pipe_data;

    always_ff @(posedge clock) begin
        if (w_do_write) begin
            for (int i = 0; i < 16; i++) begin
                if (a_bits_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= a_bits_data[8*i +: 8];
                end
            end
        end
        if (w_a_fire) begin
            r_pipe_data <= w_get_ok ? r_mem[w_idx] : 128'd0;
        end
    end

    // ------------------------------------------------------ read stage fields
    logic        r_pipe_vld;
    logic [2:0]  r_pipe_op;
    logic [3:0]  r_pipe_size;
    logic [14:0] r_pipe_src;
    logic        r_pipe_den;
    logic        r_pipe_cor;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_op   <= 3'd0;
            r_pipe_size <= 4'd0;
            r_pipe_src  <= 15'd0;
            r_pipe_den  <= 1'b0;
            r_pipe_cor  <= 1'b0;
        end else begin
            r_pipe_vld <= w_a_fire;
            if (w_a_fire) begin
                r_pipe_op   <= w_is_get ? 3'd1 : 3'd0;
                r_pipe_size <= a_bits_size;
                r_pipe_src  <= a_bits_source;
                r_pipe_den  <= !w_legal || (w_is_put && a_bits_corrupt);
                r_pipe_cor  <= w_is_get && !w_legal;
            end
        end
    end

    // -------------------------------------------------------- response queue
    // When the queue is empty the read stage drives D directly, giving T+1
    // latency; an unconsumed stage entry then drops into the queue unchanged.
    logic [c_rsp_w-1:0] r_fifo [RSP_DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_fcnt;
    logic [c_rsp_w-1:0] w_pipe_rsp;
    logic [c_rsp_w-1:0] w_head;
    logic [c_rsp_w-1:0] w_out;
    logic               w_fifo_empty;
    logic               w_d_valid;
    logic               w_d_fire;
    logic               w_push;
    logic               w_pop;

    assign w_pipe_rsp   = {r_pipe_op, r_pipe_size, r_pipe_src, r_pipe_den, r_pipe_cor, r_pipe_data};
    assign w_fifo_empty = (r_fcnt == '0);
    assign w_d_valid    = !w_fifo_empty || r_pipe_vld;
    assign w_head       = w_fifo_empty ? w_pipe_rsp : r_fifo[r_rptr];
    assign w_d_fire     = w_d_valid && d_ready;
    assign w_push       = r_pipe_vld && !(w_fifo_empty && d_ready);
    assign w_pop        = !w_fifo_empty && d_ready;
    assign w_out        = w_d_valid ? w_head : '0;

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_fifo[r_wptr] <= w_pipe_rsp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_ptr_w'(RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_ptr_w'(RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // ------------------------------------------------------------ credits
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_a_fire, w_d_fire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign a_ready        = w_a_ready;
    assign d_valid        = w_d_valid;
    assign d_bits_param   = 2'd0;
    assign d_bits_sink    = 3'd0;
    assign {d_bits_opcode, d_bits_size, d_bits_source,
            d_bits_denied, d_bits_corrupt, d_bits_data} = w_out;

endmodule

`default_nettype wire

// File: tb/tb_vx_tl_mem_responder.sv
// ============================================================================
// Module   : tb_vx_tl_mem_responder
// Brief    : Directed vector table plus multi-cycle sequences for the responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_tl_mem_responder;

    logic           clock = 1'b0;
    logic           reset;
    logic           a_valid;
    logic           a_ready;
    logic [2:0]     a_bits_opcode;
    logic [2:0]     a_bits_param;
    logic [3:0]     a_bits_size;
    logic [14:0]    a_bits_source;
    logic [31:0]    a_bits_address;
    logic [15:0]    a_bits_mask;
    logic [127:0]   a_bits_data;
    logic           a_bits_corrupt;
    logic           d_valid;
    logic           d_ready;
    logic [2:0]     d_bits_opcode;
    logic [1:0]     d_bits_param;
    logic [3:0]     d_bits_size;
    logic [14:0]    d_bits_source;
    logic [2:0]     d_bits_sink;
    logic           d_bits_denied;
    logic [127:0]   d_bits_data;
    logic           d_bits_corrupt;

    vx_tl_mem_responder dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
        .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
        .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask),
        .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
        .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
        .d_bits_sink(d_bits_sink), .d_bits_denied(d_bits_denied),
        .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt)
    );

    always #5 clock = ~clock;

    localparam logic [127:0] c_d1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] c_d2  = 128'hFEDCBA98765432100011223344556677;
    localparam logic [127:0] c_55  = {16{8'h55}};
    localparam logic [127:0] c_aa  = {16{8'hAA}};
    localparam logic [127:0] c_mrg = 128'h555555555555555555555555AAAAAAAA;

    typedef struct {
        logic [2:0]   op;
        logic [3:0]   size;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic         cor;
        logic [14:0]  src;
        logic [2:0]   e_op;
        logic         e_den;
        logic         e_cor;
        logic [127:0] e_data;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                           input logic [15:0] mask, input logic [127:0] data, input logic cor,
                           input logic [14:0] src);
        a_bits_opcode  = op;
        a_bits_size    = size;
        a_bits_address = addr;
        a_bits_mask    = mask;
        a_bits_data    = data;
        a_bits_corrupt = cor;
        a_bits_source  = src;
    endtask

    // One request with d_ready=1; response is checked in the cycle after the fire.
    task automatic run_vec(input int n, input vec_t v);
        bit fired;
        fired = 1'b0;
        d_ready = 1'b1;
        drive_a(v.op, v.size, v.addr, v.mask, v.data, v.cor, v.src);
        a_valid = 1'b1;
        for (int c = 0; c < 20 && !fired; c++) begin
            fired = a_ready;
            step();
        end
        a_valid = 1'b0;
        chk($sformatf("v%0d_fired", n), 128'(fired), 128'd1);
        chk($sformatf("v%0d_dvalid_t1", n), 128'(d_valid), 128'd1);
        chk($sformatf("v%0d_opcode", n), 128'(d_bits_opcode), 128'(v.e_op));
        chk($sformatf("v%0d_denied", n), 128'(d_bits_denied), 128'(v.e_den));
        chk($sformatf("v%0d_corrupt", n), 128'(d_bits_corrupt), 128'(v.e_cor));
        chk($sformatf("v%0d_data", n), d_bits_data, v.e_data);
        chk($sformatf("v%0d_source", n), 128'(d_bits_source), 128'(v.src));
        chk($sformatf("v%0d_size", n), 128'(d_bits_size), 128'(v.size));
        step();
        chk($sformatf("v%0d_drained", n), 128'(d_valid), 128'd0);
    endtask

    int accepted, received, bubbles, gaps, order_err, data_err;
    bit first_done, dfire, afire, started;
    logic [14:0] rcv_src;

    initial begin
        vecs[0]  = '{3'd0, 4'd4, 32'h8000_0010, 16'hFFFF, c_d1, 1'b0, 15'd1,  3'd0, 1'b0, 1'b0, 128'd0};
        vecs[1]  = '{3'd4, 4'd4, 32'h8000_0010, 16'h0000, '0,   1'b0, 15'd2,  3'd1, 1'b0, 1'b0, c_d1};
        vecs[2]  = '{3'd0, 4'd4, 32'h8000_0020, 16'hFFFF, c_55, 1'b0, 15'd3,  3'd0, 1'b0, 1'b0, 128'd0};
        vecs[3]  = '{3'd1, 4'd4, 32'h8000_0020, 16'h000F, c_aa, 1'b0, 15'd4,  3'd0, 1'b0, 1'b0, 128'd0};
        vecs[4]  = '{3'd4, 4'd4, 32'h8000_0020, 16'h0000, '0,   1'b0, 15'd5,  3'd1, 1'b0, 1'b0, c_mrg};
        vecs[5]  = '{3'd4, 4'd4, 32'h7FFF_FFF0, 16'h0000, '0,   1'b0, 15'd6,  3'd1, 1'b1, 1'b1, 128'd0};
        vecs[6]  = '{3'd4, 4'd4, 32'h8000_0008, 16'h0000, '0,   1'b0, 15'd7,  3'd1, 1'b1, 1'b1, 128'd0};
        vecs[7]  = '{3'd4, 4'd2, 32'h8000_0010, 16'h0000, '0,   1'b0, 15'd8,  3'd1, 1'b1, 1'b1, 128'd0};
        vecs[8]  = '{3'd4, 4'd4, 32'h8000_0010, 16'hFFFF, '0,   1'b0, 15'd9,  3'd1, 1'b0, 1'b0, c_d1};
        vecs[9]  = '{3'd0, 4'd4, 32'h8000_0010, 16'hFFFF, '0,   1'b1, 15'd10, 3'd0, 1'b1, 1'b0, 128'd0};
        vecs[10] = '{3'd4, 4'd4, 32'h8000_0010, 16'h0000, '0,   1'b0, 15'd11, 3'd1, 1'b0, 1'b0, c_d1};
        vecs[11] = '{3'd4, 4'd4, 32'h8000_4000, 16'h0000, '0,   1'b0, 15'd12, 3'd1, 1'b1, 1'b1, 128'd0};
        vecs[12] = '{3'd2, 4'd4, 32'h8000_0010, 16'hFFFF, '0,   1'b0, 15'd13, 3'd0, 1'b1, 1'b0, 128'd0};
        vecs[13] = '{3'd0, 4'd4, 32'h8000_4000, 16'hFFFF, c_d2, 1'b0, 15'd14, 3'd0, 1'b1, 1'b0, 128'd0};
        vecs[14] = '{3'd0, 4'd4, 32'h8000_3FF0, 16'hFFFF, c_d2, 1'b0, 15'd15, 3'd0, 1'b0, 1'b0, 128'd0};
        vecs[15] = '{3'd4, 4'd4, 32'h8000_3FF0, 16'h0000, '0,   1'b0, 15'h7FFF, 3'd1, 1'b0, 1'b0, c_d2};

        reset = 1'b1;
        a_valid = 1'b0;
        a_bits_param = 3'd5;
        d_ready = 1'b1;
        drive_a(3'd4, 4'd4, 32'h8000_0000, 16'h0, '0, 1'b0, 15'd0);
        for (int c = 0; c < 3; c++) step();
        chk("rst_a_ready", 128'(a_ready), 128'd0);
        chk("rst_d_valid", 128'(d_valid), 128'd0);
        chk("rst_d_bits", {d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
                           d_bits_sink, d_bits_denied, d_bits_corrupt}, 128'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_a_ready", 128'(a_ready), 128'd1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Backpressure: 6 Gets with d_ready low, only RSP_DEPTH are taken.
        d_ready = 1'b0;
        accepted = 0;
        drive_a(3'd4, 4'd4, 32'h8000_0010, 16'h0, '0, 1'b0, 15'd100);
        a_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            afire = a_valid && a_ready;
            step();
            if (afire) begin
                accepted++;
                a_bits_source = 15'(100 + accepted);
            end
        end
        chk("bp_accepted", 128'(accepted), 128'd4);
        chk("bp_a_ready_low", 128'(a_ready), 128'd0);
        chk("bp_d_valid_held", 128'(d_valid), 128'd1);
        chk("bp_head_source", 128'(d_bits_source), 128'd100);
        chk("bp_head_data", d_bits_data, c_d1);
        d_ready = 1'b1;
        received = 0;
        order_err = 0;
        first_done = 1'b0;
        for (int c = 0; c < 30 && received < 6; c++) begin
            dfire = d_valid && d_ready;
            afire = a_valid && a_ready;
            rcv_src = d_bits_source;
            if (dfire && rcv_src != 15'(100 + received)) order_err++;
            step();
            if (afire) begin
                accepted++;
                a_bits_source = 15'(100 + accepted);
                if (accepted >= 6) a_valid = 1'b0;
            end
            if (dfire) begin
                received++;
                if (!first_done) begin
                    first_done = 1'b1;
                    chk("bp_a_ready_reassert", 128'(a_ready), 128'd1);
                end
            end
        end
        a_valid = 1'b0;
        chk("bp_received", 128'(received), 128'd6);
        chk("bp_total_accepted", 128'(accepted), 128'd6);
        chk("bp_order_errors", 128'(order_err), 128'd0);

        // Sustained full rate: 16 back-to-back Gets.
        step();
        accepted = 0;
        received = 0;
        bubbles = 0;
        gaps = 0;
        data_err = 0;
        order_err = 0;
        started = 1'b0;
        drive_a(3'd4, 4'd4, 32'h8000_3FF0, 16'h0, '0, 1'b0, 15'd200);
        a_valid = 1'b1;
        for (int c = 0; c < 30 && received < 16; c++) begin
            if (a_valid && !a_ready) bubbles++;
            afire = a_valid && a_ready;
            dfire = d_valid && d_ready;
            if (started && !d_valid) gaps++;
            if (dfire) begin
                started = 1'b1;
                if (d_bits_data !== c_d2) data_err++;
                if (d_bits_source != 15'(200 + received)) order_err++;
            end
            step();
            if (afire) begin
                accepted++;
                a_bits_source = 15'(200 + accepted);
                if (accepted >= 16) a_valid = 1'b0;
            end
            if (dfire) received++;
        end
        a_valid = 1'b0;
        chk("burst_received", 128'(received), 128'd16);
        chk("burst_a_bubbles", 128'(bubbles), 128'd0);
        chk("burst_d_gaps", 128'(gaps), 128'd0);
        chk("burst_data_errors", 128'(data_err), 128'd0);
        chk("burst_order_errors", 128'(order_err), 128'd0);

        // Reset with three responses queued.
        step();
        d_ready = 1'b0;
        accepted = 0;
        drive_a(3'd4, 4'd4, 32'h8000_0010, 16'h0, '0, 1'b0, 15'd300);
        a_valid = 1'b1;
        for (int c = 0; c < 10 && accepted < 3; c++) begin
            afire = a_valid && a_ready;
            step();
            if (afire) accepted++;
        end
        a_valid = 1'b0;
        step();
        chk("mr_queued_valid", 128'(d_valid), 128'd1);
        reset = 1'b1;
        step();
        chk("mr_d_valid_cleared", 128'(d_valid), 128'd0);
        chk("mr_d_source_zero", 128'(d_bits_source), 128'd0);
        reset = 1'b0;
        #1;
        accepted = 0;
        a_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            afire = a_valid && a_ready;
            step();
            if (afire) accepted++;
        end
        a_valid = 1'b0;
        chk("mr_credits_restored", 128'(accepted), 128'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        run_vec(100, '{3'd4, 4'd4, 32'h8000_0010, 16'h0, '0, 1'b0, 15'd400, 3'd1, 1'b0, 1'b0, c_d1});
        run_vec(101, '{3'd4, 4'd4, 32'h8000_0020, 16'h0, '0, 1'b0, 15'd401, 3'd1, 1'b0, 1'b0, c_mrg});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
